// File: rtl/line_buffer_3row_if.sv
// Pixel-stream bus for the 3-row line buffer: raster input side and column output side.
interface line_buffer_3row_if #(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned COLW        = 10,
   parameter int unsigned ROWW        = 9
);
   logic                   in_valid;
   logic                   in_sof;
   logic [PIXEL_WIDTH-1:0] in_pixel;

   logic [PIXEL_WIDTH-1:0] pix_top;
   logic [PIXEL_WIDTH-1:0] pix_mid;
   logic [PIXEL_WIDTH-1:0] pix_bot;
   logic                   out_valid;
   logic [COLW-1:0]        out_col;
   logic [ROWW-1:0]        out_row;
   logic                   out_eol;
   logic                   out_eof;

   modport master (
      output in_valid, in_sof, in_pixel,
      input  pix_top, pix_mid, pix_bot, out_valid, out_col, out_row, out_eol, out_eof
   );

   modport slave (
      input  in_valid, in_sof, in_pixel,
      output pix_top, pix_mid, pix_bot, out_valid, out_col, out_row, out_eol, out_eof
   );
endinterface

// File: rtl/line_buffer_3row.sv
// Raster-to-column front end: two circular line memories turn a pixel stream into
// vertically aligned (row-2, row-1, row) columns for the 3x3 convolver.
module line_buffer_3row #(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned IMG_WIDTH   = 640,
   parameter int unsigned IMG_HEIGHT  = 480,
   parameter int unsigned COLW        = $clog2(IMG_WIDTH),
   parameter int unsigned ROWW        = $clog2(IMG_HEIGHT)
) (
   input logic               clk,
   input logic               rst_n,
   line_buffer_3row_if.slave bus
);

   localparam int unsigned LAST_COL  = IMG_WIDTH - 1;
   localparam int unsigned LAST_ROW  = IMG_HEIGHT - 1;
   localparam int unsigned FIRST_OUT = 2;

   logic [COLW-1:0]        col_q;
   logic [ROWW-1:0]        row_q;
   logic [COLW-1:0]        cur_col_c;
   logic [ROWW-1:0]        cur_row_c;
   logic [COLW-1:0]        nxt_col_c;
   logic [ROWW-1:0]        nxt_row_c;
   logic                   last_col_c;
   logic                   last_row_c;

   logic [PIXEL_WIDTH-1:0] l1_mem [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] l2_mem [IMG_WIDTH];

   logic [PIXEL_WIDTH-1:0] pix_top_q;
   logic [PIXEL_WIDTH-1:0] pix_mid_q;
   logic [PIXEL_WIDTH-1:0] pix_bot_q;
   logic                   out_valid_q;
   logic [COLW-1:0]        out_col_q;
   logic [ROWW-1:0]        out_row_q;
   logic                   out_eol_q;
   logic                   out_eof_q;

   // Position of the pixel on the bus (sof forces 0,0) and the position after it.
   always_comb begin
      cur_col_c = col_q;
      cur_row_c = row_q;
      if (bus.in_sof) begin
         cur_col_c = '0;
         cur_row_c = '0;
      end
      last_col_c = (cur_col_c == COLW'(LAST_COL));
      last_row_c = (cur_row_c == ROWW'(LAST_ROW));
      nxt_col_c  = cur_col_c + COLW'(1);
      nxt_row_c  = cur_row_c;
      if (last_col_c) begin
         nxt_col_c = '0;
         nxt_row_c = last_row_c ? '0 : cur_row_c + ROWW'(1);
      end
   end

   // Raster position counters; only accepted pixels advance them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (bus.in_valid) begin
         col_q <= nxt_col_c;
         row_q <= nxt_row_c;
      end
   end

   // Line memories shift down one line at the current column; reads see pre-write data.
   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         l2_mem[cur_col_c] <= l1_mem[cur_col_c];
         l1_mem[cur_col_c] <= bus.in_pixel;
      end
   end

   // Column and qualifiers; data and position hold across gaps, pulses drop to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_top_q   <= '0;
         pix_mid_q   <= '0;
         pix_bot_q   <= '0;
         out_valid_q <= 1'b0;
         out_col_q   <= '0;
         out_row_q   <= '0;
         out_eol_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else if (bus.in_valid) begin
         pix_top_q   <= l2_mem[cur_col_c];
         pix_mid_q   <= l1_mem[cur_col_c];
         pix_bot_q   <= bus.in_pixel;
         out_valid_q <= (cur_row_c >= ROWW'(FIRST_OUT));
         out_col_q   <= cur_col_c;
         out_row_q   <= cur_row_c;
         out_eol_q   <= last_col_c;
         out_eof_q   <= last_col_c && last_row_c;
      end else begin
         out_valid_q <= 1'b0;
         out_eol_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end
   end

   assign bus.pix_top   = pix_top_q;
   assign bus.pix_mid   = pix_mid_q;
   assign bus.pix_bot   = pix_bot_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_col   = out_col_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_eol   = out_eol_q;
   assign bus.out_eof   = out_eof_q;

endmodule
